// File: rtl/ln_vec_packer.sv
// Packs element beats into one N_ELEM*DW vector for the LN pipeline; closing beat -> m_valid next cycle.
// One vector can wait in the assembly buffer behind a stalled output register; s_ready drops while it does.
module ln_vec_packer #(
   parameter int N_ELEM = 64,
   parameter int DW     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DW-1:0]          s_data,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [N_ELEM*DW-1:0]   m_data,
   output logic                   err_short,
   output logic                   err_long,
   output logic [15:0]            vec_count
);

   localparam int IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam logic [IW-1:0] IDX_MAX = IW'(N_ELEM - 1);

   typedef enum logic {FILL, STALL} state_t;

   state_t                 state, state_nxt;
   logic [IW-1:0]          idx;
   logic [N_ELEM*DW-1:0]   asm_buf;
   logic [N_ELEM*DW-1:0]   full_vec;
   logic                   accept, at_max, close, slot_free;
   logic                   release_stall, load_out;

   assign s_ready   = (state == FILL);
   assign accept    = s_valid & s_ready;
   assign at_max    = (idx == IDX_MAX);
   assign close     = accept & (s_last | at_max);
   assign slot_free = ~m_valid | m_ready;
   assign load_out  = (close & slot_free) | release_stall;

   // Lanes above idx are already zero because the buffer clears on every handoff.
   always_comb begin
      full_vec = asm_buf;
      full_vec[idx*DW +: DW] = s_data;
   end

   always_comb begin
      state_nxt     = state;
      release_stall = 1'b0;
      case (state)
         FILL: begin
            if (close && !slot_free) state_nxt = STALL;
         end
         STALL: begin
            if (m_valid && m_ready) begin
               state_nxt     = FILL;
               release_stall = 1'b1;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         asm_buf   <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
         vec_count <= '0;
      end else begin
         err_short <= close & ~at_max;
         err_long  <= close & at_max & ~s_last;

         if (close && slot_free) begin
            m_data  <= full_vec;
            asm_buf <= '0;
            idx     <= '0;
         end else if (release_stall) begin
            m_data  <= asm_buf;
            asm_buf <= '0;
            idx     <= '0;
         end else if (accept) begin
            // A stalled close keeps idx; it is reset when the vector is released.
            asm_buf <= full_vec;
            if (!close) idx <= idx + IW'(1);
         end

         if (load_out)     m_valid <= 1'b1;
         else if (m_ready) m_valid <= 1'b0;

         if (load_out) vec_count <= vec_count + 16'd1;
      end
   end

endmodule
